mem_bus_master: RTL
===================

MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 Parameter DW, default 8, memory data width in bits, SHALL match the attached Memory DW.
REQ-002 Parameter AW, default 8, memory address width in bits, SHALL match the attached Memory AW.
REQ-003 clock  input  1  SHALL be the sole clock; all state updates on posedge.
REQ-004 reset_L  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 req  input  1  SHALL be the host transaction request, sampled only in IDLE.
REQ-006 wr  input  1  SHALL select the transaction type, captured with req: 1 = write, 0 = read.
REQ-007 addr  input  AW  SHALL be the start address, captured with req.
REQ-008 wdata  input  DW  SHALL be the write data, captured with req, and per beat in burst mode.
REQ-009 busy  output  1  SHALL be 1 whenever state is not IDLE.
REQ-010 ack  output  1  SHALL be a one-cycle pulse per completed beat.
REQ-011 rdata  output  DW  SHALL hold the last read beat; valid while ack=1 on reads; held otherwise.
REQ-012 mem_re, mem_we  output  1 each  SHALL be the Memory read and write enables.
REQ-013 mem_addr  output  AW  SHALL be the Memory address.
REQ-014 mem_data  inout  DW (tri)  SHALL be the Memory bidirectional data bus.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS and RESP only.
REQ-016 IDLE with req=1 at edge N SHALL capture wr/addr/wdata and enter ACCESS for cycle N+1; req=0 stays IDLE.
REQ-017 ACCESS read SHALL assert mem_re=1 and mem_addr=addr_q, and latch rdata from mem_data at end of cycle.
REQ-018 ACCESS write SHALL assert mem_we=1, mem_addr=addr_q and drive mem_data=wdata_q for that one cycle.
REQ-019 mem_data SHALL be high-Z in every state/condition other than ACCESS-write.
REQ-020 mem_re and mem_we SHALL never be 1 together; both SHALL be 0 outside ACCESS.
REQ-021 RESP SHALL assert ack=1 for exactly one cycle, then return to IDLE (single beat); ack SHALL be at N+2 after acceptance.
REQ-022 req asserted while busy SHALL be ignored and SHALL NOT be queued; back-to-back throughput SHALL be one transaction per 3 cycles.
REQ-023 wr/addr/wdata changes after capture SHALL NOT affect the transaction in flight (burst exception: REQ-028).

Reset
REQ-024 reset_L=0 SHALL immediately, without waiting for a clock: force IDLE; set busy=0, ack=0, mem_re=0, mem_we=0, mem_addr=0, rdata=0; release mem_data to high-Z.
REQ-025 Reset asserted mid-ACCESS write SHALL drop mem_we before the next edge, so the aborted write does not commit.

Configuration
REQ-026 Macro MEM_BUS_MASTER_BURST_EN defined SHALL add input burst_len[1:0], captured with req, giving beats = burst_len+1 (1..4).
REQ-027 With burst enabled, after each RESP with beats remaining, the block SHALL increment addr_q modulo 2^AW (0xFF wraps to 0x00), return to ACCESS, keep busy=1, and pulse ack once per beat.
REQ-028 With burst enabled on writes, the block SHALL re-sample wdata in each RESP cycle as the next beat's data.
REQ-029 Macro MEM_BUS_MASTER_BURST_EN undefined SHALL omit the burst_len port and beat counter, making every transaction single-beat.

Structure
REQ-030 Package mem_bus_pkg SHALL hold typedef enum mbm_state_t {IDLE, ACCESS, RESP} and default constants DEFAULT_DW=8 and DEFAULT_AW=8.
REQ-031 The address/beat counter SHALL be the single sub-module: library Counter with WIDTH=AW for addr_q (load on accept, en on beat advance); all other logic SHALL be inline.

Verification
REQ-032 Bench SHALL cover single write: req=1, wr=1, addr=0x10, wdata=0xA5 -> mem_we=1 at N+1 with mem_data=0xA5; ack at N+2; Memory[0x10]=0xA5.
REQ-033 Bench SHALL cover single read: preload Memory[0x10]=0xA5; req=1, wr=0, addr=0x10 -> mem_re=1 at N+1; at N+2 ack=1 and rdata=0xA5; mem_data never driven by the block.
REQ-034 Bench SHALL cover busy-ignore: req held high for 6 cycles -> exactly 2 transactions and 2 ack pulses, each separated by 3 cycles.
REQ-035 Bench SHALL cover reset mid-write: reset_L=0 during ACCESS-write to addr 0x20 (old value 0x00) -> mem_we falls before the edge; Memory[0x20] stays 0x00; all outputs at reset values.
REQ-036 Bench SHALL cover, with MEM_BUS_MASTER_BURST_EN, burst read: burst_len=3, addr=0xFE -> reads 0xFE, 0xFF, 0x00, 0x01; 4 ack pulses with matching rdata; busy=1 throughout; then IDLE.
REQ-037 Bench SHALL check, in every scenario, that mem_re&mem_we is never 1 and that mem_data is high-Z whenever not in ACCESS-write.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// ============================================================================
// mem_bus_pkg: shared state encoding and default widths for mem_bus_master.
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mbm_state_t;

  localparam int DEFAULT_DW = 8;
  localparam int DEFAULT_AW = 8;

endpackage

`default_nettype wire

// File: rtl/mem_bus_master_if.sv
// ============================================================================
// mem_bus_master_if: host-side request/response bundle (burst_len under MEM_BUS_MASTER_BURST_EN).
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_bus_master_if
  import mem_bus_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int AW = DEFAULT_AW
);

  logic          req;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          ack;
  logic [DW-1:0] rdata;

`ifdef MEM_BUS_MASTER_BURST_EN
  logic [1:0]    burst_len;

  modport master (output req, wr, addr, wdata, burst_len, input busy, ack, rdata);
  modport slave  (input req, wr, addr, wdata, burst_len, output busy, ack, rdata);
`else
  modport master (output req, wr, addr, wdata, input busy, ack, rdata);
  modport slave  (input req, wr, addr, wdata, output busy, ack, rdata);
`endif

endinterface

`default_nettype wire

// File: rtl/mem_bus_master_counter.sv
// ============================================================================
// mem_bus_master_counter: loadable up-counter holding the current beat address.
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_bus_master_counter #(
  parameter int WIDTH = 8
) (
  input  wire              clock,
  input  wire              reset_L,
  input  wire              load,
  input  wire              en,
  input  wire [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0] count
);

  // Natural wrap at 2^WIDTH lets bursts roll over the top of memory.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_bus_master.sv
// ============================================================================
// mem_bus_master: IDLE/ACCESS/RESP bridge from a host request to a tri-state memory.
// Rev 1.0 -- optional bursts via MEM_BUS_MASTER_BURST_EN
// ============================================================================
`default_nettype none

module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int AW = DEFAULT_AW
) (
  input  wire                clock,
  input  wire                reset_L,
  mem_bus_master_if.slave    host,
  output logic               mem_re,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  inout  wire  [DW-1:0]      mem_data
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_ACCESS = ACCESS;
  localparam logic [1:0] ST_RESP   = RESP;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          wr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [AW-1:0] addr_q;
  logic          accept;
  logic          advance;

  assign accept = (state == ST_IDLE) && host.req;

`ifdef MEM_BUS_MASTER_BURST_EN
  logic [1:0] beats_left;

  assign advance = (state == ST_RESP) && (beats_left != 2'd0);

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      beats_left <= 2'd0;
    end else if (accept) begin
      beats_left <= host.burst_len;
    end else if (advance) begin
      beats_left <= beats_left - 2'd1;
    end
  end
`else
  assign advance = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   state_nxt = accept ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = advance ? ST_ACCESS : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Write data is refreshed on every beat hand-off so bursts stream new data.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      wr_q    <= host.wr;
      wdata_q <= host.wdata;
    end else if (advance) begin
      wdata_q <= host.wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      rdata_q <= '0;
    end else if ((state == ST_ACCESS) && !wr_q) begin
      rdata_q <= mem_data;
    end
  end

  mem_bus_master_counter #(
    .WIDTH (AW)
  ) u_addr_cnt (
    .clock    (clock),
    .reset_L  (reset_L),
    .load     (accept),
    .en       (advance),
    .load_val (host.addr),
    .count    (addr_q)
  );

  // Enables decode straight from the async-reset state so reset kills them at once.
  assign mem_re   = (state == ST_ACCESS) && !wr_q;
  assign mem_we   = (state == ST_ACCESS) &&  wr_q;
  assign mem_addr = addr_q;
  assign mem_data = mem_we ? wdata_q : {DW{1'bz}};

  assign host.busy  = (state != ST_IDLE);
  assign host.ack   = (state == ST_RESP);
  assign host.rdata = rdata_q;

endmodule

`default_nettype wire
